// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Control sequencer for the multi-cycle RV32I-subset CPU. It steps one
// instruction at a time through fetch / decode / execute / memory / writeback
// and drives every datapath enable and mux select. It stalls in FETCH, MEMREAD
// and MEMWRITE until the unified memory port reports mem_ready.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active high
//   instr      in   IR contents (opcode [6:0], funct3 [14:12], funct7b5 [30])
//   eq         in   ALU equal/zero flag, used by BEQ only
//   mem_ready  in   memory access completes this cycle
//   pcwrite    out  PC load enable (pcupdate | branch & eq)
//   irwrite    out  IR / oldPC load enable
//   adrsrc     out  memory address select: 0 = PC, 1 = ALUOut
//   memwrite   out  memory write strobe
//   regwrite   out  register file write enable
//   alusrca    out  ALU A select: 00 PC, 01 oldPC, 10 RD1
//   alusrcb    out  ALU B select: 00 RD2, 01 ImmExt, 10 constant 4
//   aluctrl    out  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
//   immsrc     out  immediate type: 00 I, 01 S, 10 B, 11 J
//   resultsrc  out  result select: 00 ALUOut, 01 memory data, 10 ALU result
//   illegal    out  one-cycle pulse in DECODE for an unsupported opcode
//   state      out  current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        eq,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        irwrite,
    output logic        adrsrc,
    output logic        memwrite,
    output logic        regwrite,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  aluctrl,
    output logic [1:0]  immsrc,
    output logic [1:0]  resultsrc,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [2:0] alu_fn;
    logic [1:0] imm_dec;
    logic       pcupdate, branch;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];

    // Remaining IR bits belong to the datapath, not to control.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // NOTE: state register uses non-blocking assignment; all decode below is
    // combinational and reads only the settled register value.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign state = state_q;

    // funct3 -> ALU operation. Subtract only for R-type with funct7b5 set.
    always_comb begin
        unique case (funct3)
            3'b000:  alu_fn = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: alu_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        unique case (opcode)
            OP_STORE: imm_dec = 2'b01;
            OP_BRNCH: imm_dec = 2'b10;
            OP_JAL:   imm_dec = 2'b11;
            default:  imm_dec = 2'b00;
        endcase
    end

    // NOTE: every output and next-state is given a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d   = S_FETCH;
        irwrite   = 1'b0;
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluctrl   = ALU_ADD;
        resultsrc = 2'b00;
        illegal   = 1'b0;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        immsrc    = imm_dec;

        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                pcupdate  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRNCH:          state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe is held for the whole access, not just the last cycle.
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluctrl = alu_fn;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluctrl = alu_fn;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluctrl = ALU_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            default: begin
                // Unused encodings: all outputs stay 0, recover to FETCH.
                immsrc  = 2'b00;
                state_d = S_FETCH;
            end
        endcase

        pcwrite = pcupdate | (branch & eq);

        // A reset abandons the instruction at once: no strobe may fire in
        // the reset cycle itself.
        if (rst) begin
            pcwrite   = 1'b0;
            irwrite   = 1'b0;
            adrsrc    = 1'b0;
            memwrite  = 1'b0;
            regwrite  = 1'b0;
            alusrca   = 2'b00;
            alusrcb   = 2'b00;
            aluctrl   = ALU_ADD;
            immsrc    = 2'b00;
            resultsrc = 2'b00;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Directed stimulus for multicycle_ctrl_fsm. Each stimulus cycle pushes the
// hand-computed output vector expected during that cycle into a queue; an
// independent monitor samples the DUT on the falling edge and compares.
// Vector layout: {state, pcwrite, irwrite, adrsrc, memwrite, regwrite,
//                 illegal, alusrca, alusrcb, aluctrl, immsrc, resultsrc}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        eq;
    logic        mem_ready;
    logic        pcwrite, irwrite, adrsrc, memwrite, regwrite, illegal;
    logic [1:0]  alusrca, alusrcb, immsrc, resultsrc;
    logic [2:0]  aluctrl;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst(rst), .instr(instr), .eq(eq), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .irwrite(irwrite), .adrsrc(adrsrc),
        .memwrite(memwrite), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluctrl(aluctrl), .immsrc(immsrc),
        .resultsrc(resultsrc), .illegal(illegal), .state(state)
    );

    typedef struct {
        string       name;
        logic [20:0] v;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    wire [20:0] act = {state, pcwrite, irwrite, adrsrc, memwrite, regwrite,
                       illegal, alusrca, alusrcb, aluctrl, immsrc, resultsrc};

    // Monitor: compare on the falling edge, away from the state update.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (act !== e.v) begin
                fails++;
                $display("FAIL %s: got %b required %b", e.name, act, e.v);
            end
        end
    end

    // One stimulus cycle: drive inputs, push the expected outputs for this
    // cycle, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic r, input logic mr,
                       input logic e, input logic [31:0] ins,
                       input logic [3:0] st, input logic [5:0] strb,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic [2:0] ac, input logic [1:0] im,
                       input logic [1:0] res);
        exp_t x;
        rst = r; mem_ready = mr; eq = e; instr = ins;
        x.name = name;
        x.v = {st, strb, sa, sb, ac, im, res};
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // strb = {pcwrite, irwrite, adrsrc, memwrite, regwrite, illegal}
    task automatic fetch_go(input string n, input logic [31:0] ins, input logic [1:0] im);
        cyc(n, 0, 1, 0, ins, 4'd0, 6'b110000, 2'b00, 2'b10, 3'b000, im, 2'b10);
    endtask

    task automatic decode(input string n, input logic [31:0] ins, input logic [1:0] im);
        cyc(n, 0, 1, 1, ins, 4'd1, 6'b000000, 2'b01, 2'b01, 3'b000, im, 2'b00);
    endtask

    task automatic aluwb(input string n, input logic [31:0] ins, input logic [1:0] im);
        cyc(n, 0, 1, 1, ins, 4'd8, 6'b000010, 2'b00, 2'b00, 3'b000, im, 2'b00);
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_ADDI = 32'h40000093; // addi with bit30 set
    localparam logic [31:0] I_ORI  = 32'h0000E093;
    localparam logic [31:0] I_SLLI = 32'h00209093; // funct3 001 -> add
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0030A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    initial begin
        rst = 1'b1; mem_ready = 1'b1; eq = 1'b0; instr = I_SW;
        @(posedge clk);
        #1;
        // Reset: state 0 and every output forced low while rst is high.
        cyc("reset", 1, 1, 1, I_SW, 4'd0, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00);

        // add: 0,1,6,8
        fetch_go("add_fetch", I_ADD, 2'b00);
        decode  ("add_decode", I_ADD, 2'b00);
        cyc("add_execr", 0, 1, 1, I_ADD, 4'd6, 6'b000000, 2'b10, 2'b00, 3'b000, 2'b00, 2'b00);
        aluwb   ("add_aluwb", I_ADD, 2'b00);

        // sub, slt in EXECR
        fetch_go("sub_fetch", I_SUB, 2'b00);
        decode  ("sub_decode", I_SUB, 2'b00);
        cyc("sub_execr", 0, 1, 0, I_SUB, 4'd6, 6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00);
        aluwb   ("sub_aluwb", I_SUB, 2'b00);
        fetch_go("slt_fetch", I_SLT, 2'b00);
        decode  ("slt_decode", I_SLT, 2'b00);
        cyc("slt_execr", 0, 1, 0, I_SLT, 4'd6, 6'b000000, 2'b10, 2'b00, 3'b101, 2'b00, 2'b00);
        aluwb   ("slt_aluwb", I_SLT, 2'b00);

        // I-type: funct7b5 ignored, ori, unsupported funct3 -> add
        fetch_go("addi_fetch", I_ADDI, 2'b00);
        decode  ("addi_decode", I_ADDI, 2'b00);
        cyc("addi_execi", 0, 1, 0, I_ADDI, 4'd7, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00);
        aluwb   ("addi_aluwb", I_ADDI, 2'b00);
        fetch_go("ori_fetch", I_ORI, 2'b00);
        decode  ("ori_decode", I_ORI, 2'b00);
        cyc("ori_execi", 0, 1, 0, I_ORI, 4'd7, 6'b000000, 2'b10, 2'b01, 3'b011, 2'b00, 2'b00);
        aluwb   ("ori_aluwb", I_ORI, 2'b00);
        fetch_go("slli_fetch", I_SLLI, 2'b00);
        decode  ("slli_decode", I_SLLI, 2'b00);
        cyc("slli_execi", 0, 1, 0, I_SLLI, 4'd7, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00);
        aluwb   ("slli_aluwb", I_SLLI, 2'b00);

        // lw with 3 wait cycles in MEMREAD: 8 cycles total
        fetch_go("lw_fetch", I_LW, 2'b00);
        decode  ("lw_decode", I_LW, 2'b00);
        cyc("lw_memadr", 0, 1, 0, I_LW, 4'd2, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++)
            cyc("lw_memread_wait", 0, 0, 0, I_LW, 4'd3, 6'b001000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00);
        cyc("lw_memread_done", 0, 1, 0, I_LW, 4'd3, 6'b001000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00);
        cyc("lw_memwb", 0, 1, 0, I_LW, 4'd4, 6'b000010, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01);

        // sw with 2 wait cycles: memwrite high 3 consecutive cycles
        fetch_go("sw_fetch", I_SW, 2'b01);
        decode  ("sw_decode", I_SW, 2'b01);
        cyc("sw_memadr", 0, 1, 0, I_SW, 4'd2, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b01, 2'b00);
        cyc("sw_memwrite_w0", 0, 0, 0, I_SW, 4'd5, 6'b001100, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00);
        cyc("sw_memwrite_w1", 0, 0, 0, I_SW, 4'd5, 6'b001100, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00);
        cyc("sw_memwrite_go", 0, 1, 0, I_SW, 4'd5, 6'b001100, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00);

        // beq taken (with one FETCH stall first), then not taken
        cyc("beq_fetch_stall", 0, 0, 1, I_BEQ, 4'd0, 6'b000000, 2'b00, 2'b10, 3'b000, 2'b10, 2'b10);
        fetch_go("beq1_fetch", I_BEQ, 2'b10);
        decode  ("beq1_decode", I_BEQ, 2'b10);
        cyc("beq_taken", 0, 1, 1, I_BEQ, 4'd9, 6'b100000, 2'b10, 2'b00, 3'b001, 2'b10, 2'b00);
        fetch_go("beq0_fetch", I_BEQ, 2'b10);
        decode  ("beq0_decode", I_BEQ, 2'b10);
        cyc("beq_not_taken", 0, 1, 0, I_BEQ, 4'd9, 6'b000000, 2'b10, 2'b00, 3'b001, 2'b10, 2'b00);

        // jal: 0,1,10,8
        fetch_go("jal_fetch", I_JAL, 2'b11);
        decode  ("jal_decode", I_JAL, 2'b11);
        cyc("jal_exec", 0, 1, 0, I_JAL, 4'd10, 6'b100000, 2'b01, 2'b10, 3'b000, 2'b11, 2'b00);
        aluwb   ("jal_aluwb", I_JAL, 2'b11);

        // illegal opcode: one-cycle pulse in DECODE, back to FETCH
        fetch_go("bad_fetch", I_BAD, 2'b00);
        cyc("bad_decode", 0, 1, 0, I_BAD, 4'd1, 6'b000001, 2'b01, 2'b01, 3'b000, 2'b00, 2'b00);

        // reset asserted during MEMWRITE
        fetch_go("rsw_fetch", I_SW, 2'b01);
        decode  ("rsw_decode", I_SW, 2'b01);
        cyc("rsw_memadr", 0, 1, 0, I_SW, 4'd2, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b01, 2'b00);
        cyc("rsw_memwrite", 0, 0, 0, I_SW, 4'd5, 6'b001100, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00);
        cyc("rsw_rst_cycle", 1, 0, 0, I_SW, 4'd5, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00);
        cyc("rsw_after_rst", 0, 0, 0, I_SW, 4'd0, 6'b000000, 2'b00, 2'b10, 3'b000, 2'b01, 2'b10);
        fetch_go("rsw_refetch", I_SW, 2'b01);
        decode  ("rsw_redecode", I_SW, 2'b01);

        // Let the monitor drain; a stuck queue is itself a failure.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
